// File: rtl/csr_responder_if.sv
// csr_responder_if
//   CSR access port between the core (master) and the CSR responder (slave).
//   Signals:
//     csr          : access strobe; every strobed access also writes csr_wr_data
//     csr_rd_addr  : 12-bit CSR address (instr[31:20])
//     csr_wr_data  : final write value, already combined by the core ALU
//     csr_rd_data  : combinational read data for csr_rd_addr
//     illegal      : combinational; the strobed access is unimplemented or
//                    targets a read-only CSR
interface csr_responder_if;
  logic        csr;
  logic [11:0] csr_rd_addr;
  logic [31:0] csr_wr_data;
  logic [31:0] csr_rd_data;
  logic        illegal;

  modport master (
    output csr, csr_rd_addr, csr_wr_data,
    input  csr_rd_data, illegal
  );

  modport slave (
    input  csr, csr_rd_addr, csr_wr_data,
    output csr_rd_data, illegal
  );
endinterface

// File: rtl/csr_responder.sv
// csr_responder
//   Machine-mode CSR file and trap sequencer for the single-cycle RV32 core.
//   Serves combinational CSR reads, commits CSR writes at the clock edge,
//   runs the 64-bit cycle/instret counters and sequences trap entry (redirect
//   to mtvec) and mret (redirect to mepc).
//   Ports:
//     clk, reset      : clock, asynchronous active-low reset
//     bus (slave)     : CSR access port (csr, address, write data, read data,
//                       illegal)
//     pc              : PC of the instruction executing this cycle
//     trap            : ebreak decoded this cycle
//     mret            : mret decoded this cycle
//     instr_retire    : instruction completes this cycle
//     irq_ext         : level-sensitive external interrupt request
//     redirect        : one-cycle PC override request (decoded from state)
//     redirect_pc     : PC override target
//   Build option:
//     CSR_COUNTERS_EN : when defined, mcycle/minstret and their read-only
//                       shadows are built; otherwise those addresses decode
//                       as legal, read 0 and ignore writes.
module csr_responder #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] MISA_VAL    = 32'h4000_0100
) (
  input  logic              clk,
  input  logic              reset,
  csr_responder_if.slave    bus,
  input  logic [31:0]       pc,
  input  logic              trap,
  input  logic              mret,
  input  logic              instr_retire,
  input  logic              irq_ext,
  output logic              redirect,
  output logic [31:0]       redirect_pc
);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_ENTER  = 2'd1,
    ST_RETURN = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        mstatus_mie;
  logic        mstatus_mpie;
  logic        mie_meie;
  logic [31:0] mtvec_q;
  logic [31:0] mscratch;
  logic [31:0] mepc_q;
  logic [31:0] mcause;

  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic [63:0] mcycle_rd;
  logic [63:0] minstret_rd;

  logic        implemented;
  logic        read_only;
  logic        irq_take;
  logic        take;
  logic        do_mret;
  logic        wr_en;
  logic [31:0] cause;

  // Low two bits of mtvec/mepc are stored but always masked off on use.
  assign mtvec = mtvec_q & 32'hFFFF_FFFC;
  assign mepc  = mepc_q & 32'hFFFF_FFFC;

  assign bus.illegal = bus.csr && (!implemented || read_only);

  // Trap sources are only sampled in RUN; interrupt outranks illegal outranks ebreak.
  assign irq_take = irq_ext && mie_meie && mstatus_mie;
  assign take     = (state == ST_RUN) && (irq_take || bus.illegal || trap);
  assign do_mret  = (state == ST_RUN) && mret && !take;
  assign wr_en    = (state == ST_RUN) && bus.csr && !bus.illegal && !take;
  assign cause    = irq_take ? 32'h8000_000B : (bus.illegal ? 32'd2 : 32'd3);

  // Address decode and read mux; the read path ignores the strobe.
  always_comb begin
    bus.csr_rd_data = 32'd0;
    implemented     = 1'b1;
    read_only       = 1'b0;
    case (bus.csr_rd_addr)
      12'h300: bus.csr_rd_data = {19'd0, 2'b11, 3'd0, mstatus_mpie, 3'd0, mstatus_mie, 3'd0};
      12'h301: begin bus.csr_rd_data = MISA_VAL; read_only = 1'b1; end
      12'h304: bus.csr_rd_data = {20'd0, mie_meie, 11'd0};
      12'h305: bus.csr_rd_data = mtvec;
      12'h340: bus.csr_rd_data = mscratch;
      12'h341: bus.csr_rd_data = mepc;
      12'h342: bus.csr_rd_data = mcause;
      12'h344: begin bus.csr_rd_data = {20'd0, irq_ext, 11'd0}; read_only = 1'b1; end
      12'hB00: bus.csr_rd_data = mcycle_rd[31:0];
      12'hB80: bus.csr_rd_data = mcycle_rd[63:32];
      12'hB02: bus.csr_rd_data = minstret_rd[31:0];
      12'hB82: bus.csr_rd_data = minstret_rd[63:32];
      12'hC00: begin bus.csr_rd_data = mcycle_rd[31:0];    read_only = 1'b1; end
      12'hC80: begin bus.csr_rd_data = mcycle_rd[63:32];   read_only = 1'b1; end
      12'hC02: begin bus.csr_rd_data = minstret_rd[31:0];  read_only = 1'b1; end
      12'hC82: begin bus.csr_rd_data = minstret_rd[63:32]; read_only = 1'b1; end
      12'hF14: begin bus.csr_rd_data = HART_ID; read_only = 1'b1; end
      default: implemented = 1'b0;
    endcase
  end

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle;
  logic [63:0] minstret;
  logic        retire_en;

  assign retire_en   = instr_retire && (state == ST_RUN) && !take;
  assign mcycle_rd   = mcycle;
  assign minstret_rd = minstret;

  // A software write to either half replaces that counter's increment this cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcycle   <= 64'd0;
      minstret <= 64'd0;
    end else begin
      if (wr_en && bus.csr_rd_addr == 12'hB00)
        mcycle <= {mcycle[63:32], bus.csr_wr_data};
      else if (wr_en && bus.csr_rd_addr == 12'hB80)
        mcycle <= {bus.csr_wr_data, mcycle[31:0]};
      else
        mcycle <= mcycle + 64'd1;

      if (wr_en && bus.csr_rd_addr == 12'hB02)
        minstret <= {minstret[63:32], bus.csr_wr_data};
      else if (wr_en && bus.csr_rd_addr == 12'hB82)
        minstret <= {bus.csr_wr_data, minstret[31:0]};
      else if (retire_en)
        minstret <= minstret + 64'd1;
    end
  end
`else
  logic unused_retire;

  assign mcycle_rd     = 64'd0;
  assign minstret_rd   = 64'd0;
  assign unused_retire = instr_retire;
`endif

  // CSR state: software writes first, then trap entry or mret override mstatus.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mstatus_mie  <= 1'b0;
      mstatus_mpie <= 1'b0;
      mie_meie     <= 1'b0;
      mtvec_q      <= MTVEC_RESET;
      mscratch     <= 32'd0;
      mepc_q       <= 32'd0;
      mcause       <= 32'd0;
    end else begin
      if (wr_en) begin
        case (bus.csr_rd_addr)
          12'h300: begin
            mstatus_mie  <= bus.csr_wr_data[3];
            mstatus_mpie <= bus.csr_wr_data[7];
          end
          12'h304: mie_meie <= bus.csr_wr_data[11];
          12'h305: mtvec_q  <= bus.csr_wr_data;
          12'h340: mscratch <= bus.csr_wr_data;
          12'h341: mepc_q   <= bus.csr_wr_data;
          12'h342: mcause   <= bus.csr_wr_data;
          default: ;
        endcase
      end
      if (take) begin
        mepc_q       <= pc;
        mcause       <= cause;
        mstatus_mpie <= mstatus_mie;
        mstatus_mie  <= 1'b0;
      end else if (do_mret) begin
        mstatus_mie  <= mstatus_mpie;
        mstatus_mpie <= 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_RUN;
    else        state <= state_next;
  end

  // ENTER and RETURN each last exactly one cycle.
  always_comb begin
    state_next = ST_RUN;
    case (state)
      ST_RUN: begin
        if (take)         state_next = ST_ENTER;
        else if (do_mret) state_next = ST_RETURN;
      end
      default: state_next = ST_RUN;
    endcase
  end

  // Redirect is decoded from the registered state, so it drops with reset.
  always_comb begin
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    case (state)
      ST_ENTER: begin
        redirect    = 1'b1;
        redirect_pc = mtvec;
      end
      ST_RETURN: begin
        redirect    = 1'b1;
        redirect_pc = mepc;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csr_responder.sv
// tb_csr_responder
//   Self-checking bench for csr_responder: a table of single CSR accesses
//   followed by hand-written trap, interrupt, mret, counter and reset
//   sequences. Expected redirect targets are queued when a trap or mret is
//   driven and compared when the DUT raises redirect.
module tb_csr_responder;

  typedef struct {
    string       name;
    bit          do_write;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] pc;
    bit          exp_illegal;
    logic [31:0] exp_redir_pc;
    logic [31:0] exp_data;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        trap;
  logic        mret;
  logic        instr_retire;
  logic        irq_ext;
  logic        redirect;
  logic [31:0] redirect_pc;

  int          checks = 0;
  int          passes = 0;
  logic [31:0] redir_q[$];
  vec_t        vecs[$];

  csr_responder_if bus ();

  csr_responder dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .pc           (pc),
    .trap         (trap),
    .mret         (mret),
    .instr_retire (instr_retire),
    .irq_ext      (irq_ext),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  // Scoreboard: every redirect seen must match the oldest queued target.
  always @(negedge clk) begin
    if (reset === 1'b1 && redirect === 1'b1) begin
      if (redir_q.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_redirect: got pc %h, expected no redirect", redirect_pc);
      end else begin
        check_output("redirect_pc", redirect_pc, redir_q.pop_front());
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic add_vec(input string name, input bit do_write, input logic [11:0] addr,
                         input logic [31:0] wdata, input logic [31:0] vpc,
                         input bit exp_illegal, input logic [31:0] exp_redir_pc,
                         input logic [31:0] exp_data);
    vec_t v;
    v.name = name; v.do_write = do_write; v.addr = addr; v.wdata = wdata; v.pc = vpc;
    v.exp_illegal = exp_illegal; v.exp_redir_pc = exp_redir_pc; v.exp_data = exp_data;
    vecs.push_back(v);
  endtask

  task automatic read_check(input string name, input logic [11:0] addr, input logic [31:0] exp);
    bus.csr_rd_addr = addr;
    #1;
    check_output(name, bus.csr_rd_data, exp);
  endtask

  task automatic write_csr(input logic [11:0] addr, input logic [31:0] data);
    bus.csr = 1'b1;
    bus.csr_rd_addr = addr;
    bus.csr_wr_data = data;
    tick;
    bus.csr = 1'b0;
  endtask

  // One table entry: optional strobed access, then a read-back and an idle
  // cycle so a trap's ENTER state has drained before the next entry.
  task automatic apply_stimulus(input vec_t v);
    if (v.do_write) begin
      bus.csr = 1'b1;
      bus.csr_rd_addr = v.addr;
      bus.csr_wr_data = v.wdata;
      pc = v.pc;
      #1;
      check_output({v.name, "_illegal"}, {31'd0, bus.illegal}, {31'd0, v.exp_illegal});
      if (v.exp_illegal) redir_q.push_back(v.exp_redir_pc);
      tick;
      bus.csr = 1'b0;
      check_output({v.name, "_redirect"}, {31'd0, redirect}, {31'd0, v.exp_illegal});
    end
    read_check(v.name, v.addr, v.exp_data);
    tick;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got no finish, expected end of test");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset = 1'b0;
    bus.csr = 1'b0;
    bus.csr_rd_addr = 12'h000;
    bus.csr_wr_data = 32'd0;
    pc = 32'd0;
    trap = 1'b0;
    mret = 1'b0;
    instr_retire = 1'b0;
    irq_ext = 1'b0;

    add_vec("rd_mtvec_rst",   0, 12'h305, 32'h0,          32'h0,   0, 32'h0,   32'h0000_0100);
    add_vec("rd_mstatus_rst", 0, 12'h300, 32'h0,          32'h0,   0, 32'h0,   32'h0000_1800);
    add_vec("rd_misa",        0, 12'h301, 32'h0,          32'h0,   0, 32'h0,   32'h4000_0100);
    add_vec("rd_mhartid",     0, 12'hF14, 32'h0,          32'h0,   0, 32'h0,   32'h0);
    add_vec("rd_mcause_rst",  0, 12'h342, 32'h0,          32'h0,   0, 32'h0,   32'h0);
    add_vec("acc_unimpl",     1, 12'h7C0, 32'h1234,       32'h500, 1, 32'h100, 32'h0);
    add_vec("mcause_illegal", 0, 12'h342, 32'h0,          32'h0,   0, 32'h0,   32'h2);
    add_vec("mepc_illegal",   0, 12'h341, 32'h0,          32'h0,   0, 32'h0,   32'h500);
    add_vec("wr_mtvec",       1, 12'h305, 32'h203,        32'h0,   0, 32'h0,   32'h200);
    add_vec("wr_misa",        1, 12'h301, 32'hFFFF_FFFF,  32'h504, 1, 32'h200, 32'h4000_0100);
    add_vec("wr_mscratch",    1, 12'h340, 32'hDEAD_BEEF,  32'h0,   0, 32'h0,   32'hDEAD_BEEF);
    add_vec("wr_mepc",        1, 12'h341, 32'h1237,       32'h0,   0, 32'h0,   32'h1234);
    add_vec("wr_mie",         1, 12'h304, 32'hFFFF_FFFF,  32'h0,   0, 32'h0,   32'h800);
    add_vec("wr_mstatus",     1, 12'h300, 32'hFFFF_FFFF,  32'h0,   0, 32'h0,   32'h1888);
    add_vec("wr_mip",         1, 12'h344, 32'h0,          32'h508, 1, 32'h200, 32'h0);
    add_vec("mstatus_trap",   0, 12'h300, 32'h0,          32'h0,   0, 32'h0,   32'h1880);
    add_vec("mepc_trap",      0, 12'h341, 32'h0,          32'h0,   0, 32'h0,   32'h508);
    add_vec("wr_mhartid",     1, 12'hF14, 32'h5,          32'h50C, 1, 32'h200, 32'h0);
    add_vec("mstatus_trap2",  0, 12'h300, 32'h0,          32'h0,   0, 32'h0,   32'h1800);
    add_vec("wr_mcause",      1, 12'h342, 32'h7,          32'h0,   0, 32'h0,   32'h7);

    repeat (2) @(posedge clk);
    #1;
    check_output("rst_redirect", {31'd0, redirect}, 32'd0);
    check_output("rst_redirect_pc", redirect_pc, 32'd0);
    reset = 1'b1;
    tick;

    foreach (vecs[i]) apply_stimulus(vecs[i]);

    // ebreak with MIE set: redirect to mtvec one cycle later.
    write_csr(12'h300, 32'h8);
    pc = 32'h40;
    trap = 1'b1;
    redir_q.push_back(32'h200);
    tick;
    trap = 1'b0;
    check_output("ebreak_redirect", {31'd0, redirect}, 32'd1);
    check_output("ebreak_redirect_pc", redirect_pc, 32'h200);
    read_check("ebreak_mepc", 12'h341, 32'h40);
    read_check("ebreak_mcause", 12'h342, 32'h3);
    read_check("ebreak_mstatus", 12'h300, 32'h1880);
    tick;

    // mret returns to mepc and restores MIE from MPIE.
    mret = 1'b1;
    redir_q.push_back(32'h40);
    tick;
    mret = 1'b0;
    check_output("mret_redirect_pc", redirect_pc, 32'h40);
    read_check("mret_mstatus", 12'h300, 32'h1888);
    tick;

    // Interrupt held with MIE clear is not taken.
    write_csr(12'h300, 32'h0);
    irq_ext = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      check_output("masked_irq_redirect", {31'd0, redirect}, 32'd0);
    end
    read_check("mip_pending", 12'h344, 32'h800);
    irq_ext = 1'b0;

    // Interrupt wins over a same-cycle mscratch write.
    write_csr(12'h300, 32'h8);
    irq_ext = 1'b1;
    bus.csr = 1'b1;
    bus.csr_rd_addr = 12'h340;
    bus.csr_wr_data = 32'h55;
    pc = 32'h80;
    redir_q.push_back(32'h200);
    tick;
    bus.csr = 1'b0;
    irq_ext = 1'b0;
    read_check("irq_mscratch_kept", 12'h340, 32'hDEAD_BEEF);
    read_check("irq_mcause", 12'h342, 32'h8000_000B);
    read_check("irq_mepc", 12'h341, 32'h80);
    tick;

    // Shadow counters are read-only; the strobe is withdrawn before the edge.
    bus.csr = 1'b1;
    bus.csr_rd_addr = 12'hC00;
    #1;
    check_output("wr_cycle_shadow_illegal", {31'd0, bus.illegal}, 32'd1);
    bus.csr = 1'b0;
    tick;

`ifdef CSR_COUNTERS_EN
    bus.csr = 1'b1;
    bus.csr_rd_addr = 12'hB00;
    bus.csr_wr_data = 32'hFFFF_FFFF;
    tick;
    bus.csr_rd_addr = 12'hB80;
    tick;
    bus.csr = 1'b0;
    tick;
    tick;
    read_check("mcycle_wrap_lo", 12'hB00, 32'h1);
    read_check("mcycle_wrap_hi", 12'hB80, 32'h0);
    read_check("cycle_shadow", 12'hC00, 32'h1);
    instr_retire = 1'b1;
    repeat (10) tick;
    instr_retire = 1'b0;
    read_check("minstret_10", 12'hB02, 32'd10);
    read_check("instret_shadow", 12'hC02, 32'd10);
    read_check("minstreth_0", 12'hB82, 32'd0);
`else
    bus.csr = 1'b1;
    bus.csr_rd_addr = 12'hB00;
    bus.csr_wr_data = 32'h5;
    #1;
    check_output("mcycle_legal", {31'd0, bus.illegal}, 32'd0);
    tick;
    bus.csr = 1'b0;
    instr_retire = 1'b1;
    repeat (3) tick;
    instr_retire = 1'b0;
    read_check("mcycle_absent", 12'hB00, 32'h0);
    read_check("minstret_absent", 12'hB02, 32'h0);
`endif

    // Reset during ENTER drops redirect at once and loses the trap.
    tick;
    pc = 32'h60;
    trap = 1'b1;
    tick;
    trap = 1'b0;
    check_output("enter_before_reset", {31'd0, redirect}, 32'd1);
    reset = 1'b0;
    #1;
    check_output("reset_drops_redirect", {31'd0, redirect}, 32'd0);
    check_output("reset_drops_redirect_pc", redirect_pc, 32'd0);
    tick;
    reset = 1'b1;
    read_check("rst2_mtvec", 12'h305, 32'h100);
    read_check("rst2_mscratch", 12'h340, 32'h0);
    read_check("rst2_mstatus", 12'h300, 32'h1800);
    tick;
    check_output("rst2_no_redirect", {31'd0, redirect}, 32'd0);

    check_output("redir_queue_empty", redir_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
